// File: rtl/irq_conditioner.sv
// Per-source interrupt conditioning ahead of the PLIC: optional synchroniser,
// symmetric stability filter, then level or rising-edge output with enable.
module irq_conditioner #(
  parameter int unsigned         NumIrqs      = 32,
  parameter int unsigned         SyncStages   = 2,
  parameter logic [NumIrqs-1:0]  SyncMask     = '1,
  parameter int unsigned         FilterCycles = 4,
  parameter logic [NumIrqs-1:0]  EdgeMask     = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumIrqs-1:0] irq_i,
  input  logic [NumIrqs-1:0] enable_i,
  output logic [NumIrqs-1:0] interrupts_o,
  output logic [NumIrqs-1:0] edge_trigger_o,
  output logic [NumIrqs-1:0] filtered_o
);

  localparam int unsigned CntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

  assign edge_trigger_o = {EdgeMask[NumIrqs-1:1], 1'b0};

  // Source 0 is reserved; its inputs are intentionally ignored.
  logic unused_bit0;
  assign unused_bit0 = irq_i[0] ^ enable_i[0];

  for (genvar i = 0; i < NumIrqs; i++) begin : g_src
    if (i == 0) begin : g_tie
      assign interrupts_o[i] = 1'b0;
      assign filtered_o[i]   = 1'b0;
    end else begin : g_pipe
      localparam int unsigned Depth = SyncMask[i] ? SyncStages : 1;

      logic [Depth-1:0] chain;
      logic [CntW-1:0]  cnt;
      logic             s;
      logic             f;
      logic             f_d;
      logic             o;

      assign s = chain[Depth-1];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          chain <= '0;
          cnt   <= '0;
          f     <= 1'b0;
          f_d   <= 1'b0;
          o     <= 1'b0;
        end else begin
          chain[0] <= irq_i[i];
          for (int k = 1; k < Depth; k++) chain[k] <= chain[k-1];

          // Any return to the accepted level restarts the stability count.
          if (s == f) begin
            cnt <= '0;
          end else if (cnt == CntLast) begin
            f   <= s;
            cnt <= '0;
          end else begin
            cnt <= cnt + CntW'(1);
          end

          f_d <= f;

          if (!enable_i[i])     o <= 1'b0;
          else if (EdgeMask[i]) o <= f & ~f_d;
          else                  o <= f;
        end
      end

      assign interrupts_o[i] = o;
      assign filtered_o[i]   = f;
    end
  end

endmodule

// File: tb/tb_irq_conditioner.sv
// Bench for irq_conditioner: directed latency/glitch/edge/enable/reset cases,
// then random traffic, all against a sliding-window behavioural model.
module tb_irq_conditioner;

  localparam int          N    = 32;
  localparam int          SS   = 2;
  localparam int          FC   = 4;
  localparam logic [31:0] SYNC = 32'hFFFF_00FB;
  localparam logic [31:0] EDGE = 32'h0000_0041;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq;
  logic [N-1:0]  en;
  logic [N-1:0]  interrupts;
  logic [N-1:0]  edge_trigger;
  logic [N-1:0]  filtered;

  int n_vec = 0;
  int n_err = 0;

  // Model state: raw-sample history, s-sample window, accepted level, outputs.
  logic [31:0] ih [SS];
  logic [31:0] sh [FC];
  logic [31:0] f_m, fd_m, o_m;

  irq_conditioner #(
    .NumIrqs(N), .SyncStages(SS), .SyncMask(SYNC),
    .FilterCycles(FC), .EdgeMask(EDGE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .enable_i(en),
    .interrupts_o(interrupts), .edge_trigger_o(edge_trigger), .filtered_o(filtered)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // An input is accepted once the last FC samples of s all disagree with f.
  task automatic model_step(input logic rst, input logic [31:0] x, input logic [31:0] e);
    logic [31:0] s_pre, f_pre, diff;
    if (!rst) begin
      for (int k = 0; k < SS; k++) ih[k] = '0;
      for (int k = 0; k < FC; k++) sh[k] = '0;
      f_m = '0; fd_m = '0; o_m = '0;
      return;
    end
    for (int i = 0; i < 32; i++) s_pre[i] = SYNC[i] ? ih[SS-1][i] : ih[0][i];
    f_pre = f_m;
    for (int k = SS-1; k > 0; k--) ih[k] = ih[k-1];
    ih[0] = x;
    for (int k = FC-1; k > 0; k--) sh[k] = sh[k-1];
    sh[0] = s_pre;
    diff = '1;
    for (int k = 0; k < FC; k++) diff &= sh[k] ^ f_pre;
    o_m  = e & ((EDGE & f_pre & ~fd_m) | (~EDGE & f_pre));
    fd_m = f_pre;
    f_m  = f_pre ^ diff;
    f_m[0] = 1'b0; fd_m[0] = 1'b0; o_m[0] = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(rst_n, irq, en);
    #1;
    chk("irq_out", interrupts, o_m);
    chk("filtered", filtered, f_m);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; en = '1;
    settle(3);
    chk("reset_out", interrupts, 32'h0);
    chk("reset_filt", filtered, 32'h0);
    chk("edge_trig", edge_trigger, 32'h0000_0040);
    rst_n = 1'b1;
    settle(10);

    // Level latency on synced bit 3.
    irq[3] = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      if (k == 20) irq[3] = 1'b0;
      cyc();
      if (k < 20) begin
        chk("lvl_filt3", 32'(filtered[3]), 32'(k >= 5));
        chk("lvl_rise3", 32'(interrupts[3]), 32'(k >= 6));
      end else begin
        chk("lvl_fall3", 32'(interrupts[3]), 32'(k < 26));
      end
    end
    settle(10);

    // Glitch reject on unsynced bit 2: 3-cycle pulse, then 4-cycle pulse.
    for (int k = 0; k < 15; k++) begin
      irq[2] = (k < 3);
      cyc();
      chk("glitch3", 32'(interrupts[2]), 32'h0);
    end
    for (int k = 0; k < 15; k++) begin
      irq[2] = (k < 4);
      cyc();
      chk("pulse4", 32'(interrupts[2]), 32'(k >= 5 && k <= 8));
    end
    settle(10);

    // Edge mode on bit 6: two 50-cycle highs with a 10-cycle gap.
    for (int k = 0; k < 130; k++) begin
      irq[6] = (k < 50) || (k >= 60 && k < 110);
      cyc();
      chk("edge6", 32'(interrupts[6]), 32'(k == 6 || k == 66));
    end
    chk("edge_trig2", edge_trigger, 32'h0000_0040);

    // Enable gating: level bit 5 then edge bit 6.
    en[5] = 1'b0; irq[5] = 1'b1;
    settle(10);
    chk("gate_lvl_off", 32'(interrupts[5]), 32'h0);
    chk("gate_lvl_filt", 32'(filtered[5]), 32'h1);
    en[5] = 1'b1;
    cyc();
    chk("gate_lvl_on", 32'(interrupts[5]), 32'h1);
    en[6] = 1'b0; irq[6] = 1'b1;
    settle(10);
    en[6] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("gate_edge", 32'(interrupts[6]), 32'h0);
    end
    irq = '0;
    settle(12);

    // Reset two cycles into filtering on bit 4, with bit 0 driven high.
    irq[0] = 1'b1; irq[4] = 1'b1;
    settle(4);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst_out", interrupts, 32'h0);
      chk("rst_filt", filtered, 32'h0);
    end
    rst_n = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      cyc();
      chk("rst_rise4", 32'(interrupts[4]), 32'(k >= 6));
      chk("bit0", 32'(interrupts[0]), 32'h0);
    end

    // Random traffic with biased toggling so short pulses hit the filter edge.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) irq[i] = ~irq[i];
      if ((t % 64) == 0) en = $urandom | $urandom;
      if (rst_n && $urandom_range(499) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(1) == 0) rst_n = 1'b1;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_conditioner.md
# irq_conditioner

Per-source interrupt conditioning stage that sits directly upstream of the PLIC. It takes raw peripheral interrupt lines and drives the PLIC `interrupts_i` / `edge_trigger_i` inputs. Sources include UART, SDHCI, the Ethernet MAC/DMA/PHY, and the external PHY pin. Each source is optionally synchronised, glitch-filtered by a stability counter, and presented either as a level or as a one-cycle rising-edge pulse, with a per-source enable.

## Interface
- `NumIrqs`, 32, number of interrupt sources; bit 0 is reserved and is always driven 0.
- `SyncStages`, 2, flop depth for sources selected by `SyncMask`; must be ≥2.
- `SyncMask`, `'1`, per-source: 1 = asynchronous source, use `SyncStages` flops; 0 = synchronous source, use 1 flop.
- `FilterCycles`, 4, consecutive cycles a changed input must persist before it is accepted; must be ≥1, and 1 means no filtering.
- `EdgeMask`, `'0`, per-source: 1 = edge mode (pulse output), 0 = level mode.
- `clk_i`, input, 1, the single clock.
- `rst_ni`, input, 1, reset: synchronous, active-low.
- `irq_i`, input, NumIrqs, raw interrupt lines, possibly asynchronous.
- `enable_i`, input, NumIrqs, per-source output enable, synchronous to `clk_i`.
- `interrupts_o`, output, NumIrqs, conditioned interrupts to the PLIC; registered.
- `edge_trigger_o`, output, NumIrqs, constant equal to `EdgeMask` with bit 0 forced 0.
- `filtered_o`, output, NumIrqs, debug: accepted (filtered) level per source, before enable and edge logic.

## Operation
Each source has an independent, identical pipeline:
- **Input stage.** The shift chain has depth D = `SyncStages` if the `SyncMask` bit is set, otherwise 1. Call the last-stage output `s`.
- **Filter.**
  - State: accepted level `f` and counter `c`, with width `$clog2(FilterCycles)`, minimum 1.
  - If `s == f`: `c <= 0`.
  - Else if `c == FilterCycles-1`: `f <= s`, `c <= 0`.
  - Else: `c <= c+1`.
  - A pulse or glitch shorter than `FilterCycles` cycles is discarded, and the counter restarts on any return to `f`.
  - The filter is symmetric: it applies to both rising and falling changes.
- **Edge-detect register.** `f_d <= f`.
- **Output register `o`**, which drives `interrupts_o`:
  - `enable_i == 0`: `o <= 0`.
  - Level mode: `o <= f`.
  - Edge mode: `o <= f & ~f_d`, giving one pulse per accepted rising transition. Falling transitions produce nothing.
- **Enable behaviour.**
  - `enable_i` gates only `o`. The input stage, `f`, `c` and `f_d` keep tracking while disabled.
  - Enabling a level-mode source while `f = 1` gives `o = 1` on the next cycle.
  - Enabling an edge-mode source while `f = 1` gives no pulse.
  - An edge-mode pulse that falls while disabled is lost, not deferred.
- **Bit 0:** all its registers are tied off; `interrupts_o[0]` is 0 at all times.
- `filtered_o = f`.

## Timing
- **Reset:** while `rst_ni` is 0 at a rising edge, every stage flop, `f`, `c`, `f_d` and `o` become 0. Hence `interrupts_o` = 0 and `filtered_o` = 0.
- **Reset mid-operation:** the same clear applies and any partial count is lost. If `irq_i` is held high through reset release, it is treated as a fresh 0→1 change. Edge-mode sources therefore emit one pulse after release.
- **Latency.** An `irq_i` change is sampled at edge 0 and stays stable thereafter.
  - `s` changes at edge D-1.
  - `f` changes at edge D-1+`FilterCycles`.
  - `o` changes at edge D+`FilterCycles`.
  - With defaults: 6 edges for synced sources, 5 edges for unsynced sources.
- **Edge mode:** `o` is high for exactly 1 cycle, at the same edge a level-mode `o` would rise.
- **Minimum accepted input width:** `FilterCycles` cycles, measured at `s`.
- **Minimum edge-pulse spacing:** 2×`FilterCycles` cycles (high phase plus low phase).
- **Throughput:** no back-pressure. Every source is evaluated every cycle, and sources are fully independent.
- **Counter:** `c` never exceeds `FilterCycles-1` and never wraps.

## Test plan
- **Level latency.** Defaults, `enable_i='1`. Raise `irq_i[3]` at edge 0 → `filtered_o[3]` rises at edge 5 and `interrupts_o[3]` at edge 6. Drop it at edge 20 → `interrupts_o[3]` falls at edge 26.
- **Glitch reject.** `FilterCycles=4`, `SyncMask[2]=0`. A 3-cycle high pulse on `irq_i[2]` → `interrupts_o[2]` stays 0. A 4-cycle pulse → `interrupts_o[2]` is high for 4 cycles, starting at edge 5.
- **Edge mode.** `EdgeMask[6]=1`. Hold `irq_i[6]` high for 50 cycles, twice, separated by a 10-cycle low gap → exactly two 1-cycle pulses on `interrupts_o[6]`, 60 cycles apart. Meanwhile `edge_trigger_o` = 0x40.
- **Enable gating.** Level source held high with `enable_i` 0 → output 0. Set `enable_i` → output 1 on the next edge. Repeat on an edge-mode source → no pulse.
- **Reset mid-count.** Reset 2 cycles into filtering, with `irq_i[4]` held high → all outputs 0 during reset. `interrupts_o[4]` rises 6 edges after the first edge with `rst_ni=1`. Bit 0 stays 0 even with `irq_i[0]` driven high.
